seg_scan_driver: RTL and testbench

Time-multiplexed scan driver for the board's eight seven-segment tubes. The tubes are split into two groups of four, and each group has its own segment bus. The block sits directly downstream of the display-pattern generators, which produce per-digit 8-bit segment patterns. It latches one full frame of patterns at each frame boundary, then cycles through the four digit slots. Both groups are driven at the same time, and a blanking window at the start of each slot suppresses ghosting.

---
 rtl/seg_pkg.sv | 15 +
 rtl/scan_counter.sv | 35 +++
 rtl/seg_scan_driver.sv | 69 ++++++
 tb/tb_seg_scan_driver.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg_pkg;
  localparam int DIGITS       = 8;
  localparam int GROUP_DIGITS = 4;
  localparam int NUM_GROUPS   = DIGITS / GROUP_DIGITS;
  localparam int SLOT_W       = $clog2(GROUP_DIGITS);
  localparam int DIG_W        = $clog2(DIGITS);

  // Segment order MSB..LSB is {a,b,c,d,e,f,g,dp}, active-high.
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0   = 8'b1111_1100;
  localparam seg_t SEG_2   = 8'b1101_1010;
  localparam seg_t SEG_OFF = 8'h00;
endpackage

// File: rtl/scan_counter.sv
// Slot timebase: divides clk into digit slots and flags blanking and frame start.
module scan_counter
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [SLOT_W-1:0] slot,
  output logic              in_blank,
  output logic              frame_tick
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] LAST    = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_W = DW'(BLANK_CYCLES);

  logic [DW-1:0] div_cnt;

  // Slot counter wraps naturally since GROUP_DIGITS is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      slot    <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      slot    <= slot + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign in_blank   = div_cnt < BLANK_W;
  assign frame_tick = (div_cnt == '0) && (slot == '0);
endmodule

// File: rtl/seg_scan_driver.sv
// Two-group time-multiplexed seven-segment driver with frame shadowing and slot blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] digits_in,
  input  logic [7:0]  blank_mask,
  output logic [7:0]  seg_right,
  output logic [7:0]  seg_left,
  output logic [7:0]  tub_sel,
  output logic        frame_start
);
  logic [SLOT_W-1:0] slot;
  logic              in_blank;
  logic              frame_tick;

  seg_t [DIGITS-1:0] shadow_dig;
  logic [DIGITS-1:0] shadow_mask;

  logic [NUM_GROUPS-1:0][GROUP_DIGITS-1:0] tub_nxt;
  seg_t [NUM_GROUPS-1:0]                   seg_nxt;

  scan_counter #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .slot       (slot),
    .in_blank   (in_blank),
    .frame_tick (frame_tick)
  );

  // Every group scans the same slot index within its own block of digits.
  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    logic [DIG_W-1:0] idx;
    logic             lit;
    assign idx        = DIG_W'(g * GROUP_DIGITS) + DIG_W'(slot);
    assign lit        = enable && !in_blank && !shadow_mask[idx];
    assign tub_nxt[g] = lit ? ({{(GROUP_DIGITS-1){1'b0}}, 1'b1} << slot) : '0;
    assign seg_nxt[g] = lit ? shadow_dig[idx] : SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_dig  <= '0;
      shadow_mask <= '0;
      tub_sel     <= '0;
      seg_right   <= SEG_OFF;
      seg_left    <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      // Inputs are only sampled at the frame boundary so a frame never tears.
      if (frame_tick) begin
        shadow_dig  <= digits_in;
        shadow_mask <= blank_mask;
      end
      frame_start <= frame_tick;
      tub_sel     <= tub_nxt;
      seg_right   <= seg_nxt[0];
      seg_left    <= seg_nxt[1];
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: edge-count reference model feeds a queue, monitor compares every cycle.
module tb_seg_scan_driver;
  import seg_pkg::*;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] digits_in;
  logic [7:0]  blank_mask;
  logic [7:0]  seg_right, seg_left, tub_sel;
  logic        frame_start;

  typedef struct packed {
    logic [7:0] tub;
    logic [7:0] r;
    logic [7:0] l;
    logic       fs;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release and the latched frame.
  int          e = 0;
  logic [63:0] sh_d = '0;
  logic [7:0]  sh_m = '0;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .digits_in   (digits_in),
    .blank_mask  (blank_mask),
    .seg_right   (seg_right),
    .seg_left    (seg_left),
    .tub_sel     (tub_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Predict the result of the coming edge from the current inputs, then advance one cycle.
  task automatic cyc();
    exp_t x;
    int t, sl, dc;
    x = '0;
    if (rst) begin
      e = 0; sh_d = '0; sh_m = '0;
    end else begin
      t  = e % FRAME;
      sl = t / SD;
      dc = t % SD;
      x.fs = (t == 0);
      if (enable && dc >= BC) begin
        if (!sh_m[sl])     begin x.tub[sl]     = 1'b1; x.r = sh_d[sl*8 +: 8];     end
        if (!sh_m[4 + sl]) begin x.tub[4 + sl] = 1'b1; x.l = sh_d[(4+sl)*8 +: 8]; end
      end
      if (t == 0) begin sh_d = digits_in; sh_m = blank_mask; end
      e++;
    end
    q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic base_digits();
    digits_in = '0;
    digits_in[7:0]   = SEG_0;
    digits_in[39:32] = SEG_2;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  // Monitor: scoreboard compare plus group one-hot and frame period invariants.
  int cyc_cnt = 0;
  int last_fs = -1;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mx = q.pop_front();
      checks++;
      if (tub_sel !== mx.tub || seg_right !== mx.r || seg_left !== mx.l || frame_start !== mx.fs) begin
        errors++;
        $display("FAIL scoreboard t=%0t got tub=%b r=%h l=%h fs=%b want tub=%b r=%h l=%h fs=%b",
                 $time, tub_sel, seg_right, seg_left, frame_start, mx.tub, mx.r, mx.l, mx.fs);
      end
      checks++;
      if (!$onehot0(tub_sel[3:0]) || !$onehot0(tub_sel[7:4])) begin
        errors++;
        $display("FAIL onehot t=%0t got tub=%b want each nibble one-hot or zero", $time, tub_sel);
      end
      if (rst) last_fs = -1;
      else if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (cyc_cnt - last_fs != FRAME) begin
            errors++;
            $display("FAIL frame_period t=%0t got %0d want %0d", $time, cyc_cnt - last_fs, FRAME);
          end
        end
        last_fs = cyc_cnt;
      end
    end
    cyc_cnt++;
  end

  initial begin
    rst = 1'b1; enable = 1'b0; digits_in = '0; blank_mask = '0;
    cyc(); cyc();

    // Basic scan, then a mid-frame digit change that must wait for the next frame.
    rst = 1'b0; enable = 1'b1; base_digits();
    for (int i = 0; i < 72; i++) begin
      if (i == 12) digits_in[7:0] = 8'h60;
      cyc();
    end

    // Digit 0 masked off.
    do_reset(); base_digits(); blank_mask = 8'h01;
    for (int i = 0; i < 40; i++) cyc();

    // Enable dropped mid-slot and restored later.
    blank_mask = '0; do_reset();
    for (int i = 0; i < 40; i++) begin
      enable = !(i >= 5 && i < 20);
      cyc();
    end
    enable = 1'b1;

    // One-cycle reset in the middle of slot 1.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      rst = (i == 13);
      cyc();
    end
    rst = 1'b0;

    // Ten frames of random digits, masks and enable glitches without reset.
    do_reset();
    for (int i = 0; i < 10 * FRAME; i++) begin
      if ($urandom_range(7) == 0)  digits_in  = {$urandom, $urandom};
      if ($urandom_range(15) == 0) blank_mask = 8'($urandom);
      if ($urandom_range(15) == 0) enable     = ~enable;
      cyc();
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 200; i++) begin
      digits_in  = {$urandom, $urandom};
      blank_mask = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
      enable     = ($urandom_range(9) != 0);
      rst        = ($urandom_range(49) == 0);
      cyc();
    end
    rst = 1'b0;

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
